mono_to_stereo: RTL and testbench

MONO_TO_STEREO -- requirements
Module: mono_to_stereo

---
 rtl/mono_to_stereo_if.sv | 32 +++
 rtl/mono_to_stereo.sv | 101 ++++++++++
 tb/tb_mono_to_stereo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mono_to_stereo_if.sv
// Stream bundle for the mono-to-stereo expander: mono sample input side,
// stereo channel-word output side, plus mute control and diagnostics.
interface mono_to_stereo_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24
);
  logic                 mute;
  logic [IN_WIDTH-1:0]  s_axis_data;
  logic                 s_axis_valid;
  logic                 s_axis_ready;
  logic                 s_axis_last;
  logic [OUT_WIDTH-1:0] m_axis_data;
  logic                 m_axis_valid;
  logic                 m_axis_ready;
  logic                 m_axis_last;
  logic                 frame_end;
  logic [15:0]          underrun_count;

  // Expander side: consumes mono samples, produces channel words.
  modport slave (
    input  mute, s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last,
           frame_end, underrun_count
  );

  // Environment side: produces mono samples, consumes channel words.
  modport master (
    output mute, s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last,
           frame_end, underrun_count
  );
endinterface

// File: rtl/mono_to_stereo.sv
// Mono-to-stereo expander: each accepted mono sample is left-justified into
// an OUT_WIDTH word and emitted twice (left word, then right word) toward
// the I2S2 transmit stream. Back-to-back samples sustain one sample per two
// cycles because a new sample may be taken on the right-word handshake.
module mono_to_stereo #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  mono_to_stereo_if.slave  bus
);
  localparam int PAD = OUT_WIDTH - IN_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_L = 2'd1,
    SEND_R = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [OUT_WIDTH-1:0] sample_reg;
  logic                 last_reg;
  logic                 frame_end_reg;
  logic [15:0]          underrun_reg;
  logic [OUT_WIDTH-1:0] justified;
  logic                 in_hs;
  logic                 s_ready;

  // A narrower output word cannot hold the sample; refuse to elaborate.
  if (OUT_WIDTH < IN_WIDTH) begin : g_width_check
    $error("mono_to_stereo: OUT_WIDTH must be >= IN_WIDTH");
  end

  // Left-justify: the sample MSB lands on the word MSB, so the sign is kept
  // and the low PAD bits are zero.
  for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_just
    if (gi < PAD) begin : g_pad
      assign justified[gi] = 1'b0;
    end else begin : g_bit
      assign justified[gi] = bus.s_axis_data[gi-PAD];
    end
  end

  // Ready in IDLE, or in SEND_R when the right word leaves this cycle.
  assign s_ready = (state_reg == IDLE) ||
                   ((state_reg == SEND_R) && bus.m_axis_ready);
  assign in_hs   = bus.s_axis_valid && s_ready;

  assign bus.s_axis_ready   = s_ready;
  assign bus.m_axis_valid   = (state_reg != IDLE);
  assign bus.m_axis_last    = (state_reg == SEND_R);
  assign bus.m_axis_data    = sample_reg;
  assign bus.frame_end      = frame_end_reg;
  assign bus.underrun_count = underrun_reg;

  // State register; reset drops straight to IDLE so valid falls at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic for the left/right word sequencing.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_hs) state_next = SEND_L;
      SEND_L:  if (bus.m_axis_ready) state_next = SEND_R;
      SEND_R:  if (bus.m_axis_ready) state_next = in_hs ? SEND_L : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the sample and its frame marker; mute only matters here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg <= '0;
      last_reg   <= 1'b0;
    end else if (in_hs) begin
      sample_reg <= bus.mute ? '0 : justified;
      last_reg   <= bus.s_axis_last;
    end
  end

  // One-cycle pulse after the right word of a frame-final sample leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_end_reg <= 1'b0;
    else       frame_end_reg <= (state_reg == SEND_R) && bus.m_axis_ready && last_reg;
  end

  // Count cycles where the sink wanted data but no sample was offered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_reg <= '0;
    end else if ((state_reg == IDLE) && bus.m_axis_ready && !bus.s_axis_valid &&
                 (underrun_reg != 16'hFFFF)) begin
      underrun_reg <= underrun_reg + 16'd1;
    end
  end
endmodule

// File: tb/tb_mono_to_stereo.sv
// Directed bench for mono_to_stereo: basic expansion, back-to-back samples,
// downstream stall, mute with frame marker, reset mid-sample, and underrun
// counter saturation. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_mono_to_stereo;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  mono_to_stereo_if #(.IN_WIDTH(16), .OUT_WIDTH(24)) bus ();

  mono_to_stereo #(.IN_WIDTH(16), .OUT_WIDTH(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Check one output word at the falling edge.
  task automatic check_word(input string tag, input logic [23:0] data, input logic last);
    @(negedge clk);
    check_val({tag, ".valid"}, bus.m_axis_valid, 1'b1);
    check_val({tag, ".data"},  bus.m_axis_data,  data);
    check_val({tag, ".last"},  bus.m_axis_last,  last);
  endtask

  initial begin
    reset            = 1'b1;
    bus.mute         = 1'b0;
    bus.s_axis_data  = '0;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_last  = 1'b0;
    bus.m_axis_ready = 1'b0;

    // Reset state
    #2;
    check_val("rst.valid",    bus.m_axis_valid,   1'b0);
    check_val("rst.data",     bus.m_axis_data,    24'h0);
    check_val("rst.last",     bus.m_axis_last,    1'b0);
    check_val("rst.frame_end", bus.frame_end,     1'b0);
    check_val("rst.underrun", bus.underrun_count, 16'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst.s_ready", bus.s_axis_ready, 1'b1);
    next_cycle();

    // 0x1234 -> 0x123400 left then right
    bus.m_axis_ready = 1'b1;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 16'h1234;
    next_cycle();
    bus.s_axis_valid = 1'b0;
    check_word("t1.L", 24'h123400, 1'b0);
    check_val("t1.L.s_ready", bus.s_axis_ready, 1'b0);
    next_cycle();
    check_word("t1.R", 24'h123400, 1'b1);
    next_cycle();
    bus.m_axis_ready = 1'b0;
    @(negedge clk);
    check_val("t1.idle.valid", bus.m_axis_valid, 1'b0);
    check_val("t1.underrun",   bus.underrun_count, 16'h0);
    next_cycle();

    // 0x8000 then 0x7FFF back-to-back, four words on four cycles
    bus.m_axis_ready = 1'b1;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 16'h8000;
    next_cycle();
    bus.s_axis_data  = 16'h7FFF;
    check_word("t2.w0", 24'h800000, 1'b0);
    next_cycle();
    check_word("t2.w1", 24'h800000, 1'b1);
    check_val("t2.w1.s_ready", bus.s_axis_ready, 1'b1);
    next_cycle();
    bus.s_axis_valid = 1'b0;
    check_word("t2.w2", 24'h7FFF00, 1'b0);
    next_cycle();
    check_word("t2.w3", 24'h7FFF00, 1'b1);
    next_cycle();
    bus.m_axis_ready = 1'b0;
    @(negedge clk);
    check_val("t2.idle.valid", bus.m_axis_valid, 1'b0);
    next_cycle();

    // Downstream stall for 5 cycles in SEND_L; mute toggles mid-stall
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 16'hABCD;
    next_cycle();
    bus.s_axis_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.mute = 1'b1;
      check_word($sformatf("t3.stall%0d", i), 24'hABCD00, 1'b0);
      next_cycle();
    end
    bus.mute         = 1'b0;
    bus.m_axis_ready = 1'b1;
    check_word("t3.L", 24'hABCD00, 1'b0);
    next_cycle();
    check_word("t3.R", 24'hABCD00, 1'b1);
    next_cycle();
    bus.m_axis_ready = 1'b0;
    next_cycle();

    // Muted sample with frame marker
    bus.m_axis_ready = 1'b1;
    bus.mute         = 1'b1;
    bus.s_axis_last  = 1'b1;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 16'h5555;
    next_cycle();
    bus.s_axis_valid = 1'b0;
    bus.mute         = 1'b0;
    bus.s_axis_last  = 1'b0;
    check_word("t4.L", 24'h000000, 1'b0);
    check_val("t4.L.frame_end", bus.frame_end, 1'b0);
    next_cycle();
    check_word("t4.R", 24'h000000, 1'b1);
    check_val("t4.R.frame_end", bus.frame_end, 1'b0);
    next_cycle();
    bus.m_axis_ready = 1'b0;
    @(negedge clk);
    check_val("t4.pulse.frame_end", bus.frame_end, 1'b1);
    check_val("t4.pulse.valid",     bus.m_axis_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check_val("t4.after.frame_end", bus.frame_end, 1'b0);
    next_cycle();

    // Reset asserted while in SEND_R
    bus.m_axis_ready = 1'b1;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 16'h1111;
    next_cycle();
    bus.s_axis_valid = 1'b0;
    next_cycle();
    bus.m_axis_ready = 1'b0;
    #2;
    check_val("t5.pre.valid", bus.m_axis_valid, 1'b1);
    check_val("t5.pre.last",  bus.m_axis_last,  1'b1);
    reset = 1'b1;
    #1;
    check_val("t5.rst.valid", bus.m_axis_valid, 1'b0);
    check_val("t5.rst.data",  bus.m_axis_data,  24'h0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("t5.after%0d.valid", i), bus.m_axis_valid, 1'b0);
      next_cycle();
    end
    check_val("t5.underrun", bus.underrun_count, 16'h0);

    // Underrun counting and saturation
    bus.m_axis_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("t6.underrun10", bus.underrun_count, 16'd10);
    repeat (69990) @(posedge clk);
    @(negedge clk);
    check_val("t6.underrun_sat", bus.underrun_count, 16'hFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t6.underrun_hold", bus.underrun_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
